tile_pixel_pipe: RTL

- Pipelined background renderer for the VGA path.
- Takes the raster position each pixel and looks up the 4-bit tile id in an internal 40×30 tile map. It then fetches that tile's 4-bit pixel from the tile ROM and hands the result to the palette stage.
- Sync and blank are delayed to stay aligned with the index.
- Owns a reset-time clear sequencer and a single-cycle write port used by game logic to place tiles.

---
 rtl/tile_pkg.sv | 42 ++++
 rtl/tile_rom.sv | 18 +
 rtl/tile_pixel_pipe.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared constants, types and tile ROM contents for the tile background renderer.
package tile_pkg;

    localparam int MAP_W     = 40;
    localparam int MAP_H     = 30;
    localparam int TILE_BITS = 4;
    localparam int MAP_CELLS = MAP_W * MAP_H;
    localparam int CELL_W    = 11;
    localparam int ROM_AW    = 12;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } tp_state_t;

    // Per-pixel control bundle carried alongside the map/ROM reads.
    typedef struct packed {
        logic [3:0] px;
        logic [3:0] py;
        logic       in_range;
        logic       blank_n;
        logic       hs;
        logic       vs;
    } tp_ctl_t;

    // Idle levels: blanked, syncs inactive (high).
    localparam tp_ctl_t CTL_IDLE = '{px: 4'h0, py: 4'h0, in_range: 1'b0,
                                     blank_n: 1'b0, hs: 1'b1, vs: 1'b1};

    // Tile artwork generator. Address layout is {tile[3:0], py[3:0], px[3:0]};
    // the pattern keeps every tile (including tile 0) visibly non-uniform.
    function automatic logic [3:0] tile_rom_word(input logic [ROM_AW-1:0] a);
        logic [3:0] tile;
        logic [3:0] py;
        logic [3:0] px;
        tile = a[11:8];
        py   = a[7:4];
        px   = a[3:0];
        return (tile ^ py ^ {px[1:0], px[3:2]}) + 4'd1;
    endfunction

endpackage

// File: rtl/tile_rom.sv
// 4096x4 synchronous tile ROM; contents come from the package artwork table.
module tile_rom
    import tile_pkg::*;
(
    input  logic              Clk,
    input  logic              rd_en,
    input  logic [ROM_AW-1:0] addr,
    output logic [3:0]        q
);

    // Registered lookup, advanced only when the read is enabled.
    always_ff @(posedge Clk) begin
        if (rd_en) begin
            q <= tile_rom_word(addr);
        end
    end

endmodule

// File: rtl/tile_pixel_pipe.sv
// Three-stage tile background renderer: address calc, map read, ROM read.
// Includes the reset-time map clear sequencer and the game-logic write port.
//
// state | meaning
// CLEAR | writing tile 0 into cells 0..MAP_CELLS-1, one per clock; writes blocked
// RUN   | normal rendering; write port open
module tile_pixel_pipe
    import tile_pkg::*;
#(
    parameter int MAP_W     = tile_pkg::MAP_W,
    parameter int MAP_H     = tile_pkg::MAP_H,
    parameter int TILE_BITS = tile_pkg::TILE_BITS
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 pix_en,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic                 blank_n_in,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic                 map_we,
    input  logic [CELL_W-1:0]    map_addr,
    input  logic [TILE_BITS-1:0] map_data,
    output logic                 map_ready,
    output logic [3:0]           index,
    output logic                 blank_n_out,
    output logic                 hs_out,
    output logic                 vs_out
);

    localparam int NCELLS = MAP_W * MAP_H;

    tp_state_t            state_q;
    logic [CELL_W-1:0]    clr_addr_q;
    logic                 map_ready_q;

    logic                 wr_en;
    logic [CELL_W-1:0]    wr_addr;
    logic [TILE_BITS-1:0] wr_data;
    logic [TILE_BITS-1:0] map_mem [NCELLS];

    logic                 in_range;
    logic [CELL_W-1:0]    cell_calc;
    logic [CELL_W-1:0]    cell_d;
    tp_ctl_t              ctl_d;

    logic [CELL_W-1:0]    cell_s1_q;
    tp_ctl_t              ctl_s1_q;
    logic [TILE_BITS-1:0] tile_s2_q;
    tp_ctl_t              ctl_s2_q;
    logic                 vis_s3_q;
    logic                 blank_s3_q;
    logic                 hs_s3_q;
    logic                 vs_s3_q;

    logic [ROM_AW-1:0]    rom_addr;
    logic [3:0]           rom_q;

    // Clear sequencer: walk every cell once after reset, then stay in RUN.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            map_ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_addr_q == CELL_W'(NCELLS - 1)) begin
                        state_q     <= RUN;
                        map_ready_q <= 1'b1;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                RUN:     state_q <= RUN;
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign map_ready = map_ready_q;

    // Single write port: clear sequencer owns it in CLEAR, game logic in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_addr_q;
        wr_data = '0;
        if (!Reset) begin
            if (state_q == CLEAR) begin
                wr_en = 1'b1;
            end else if (map_we && (map_addr < CELL_W'(NCELLS))) begin
                wr_en   = 1'b1;
                wr_addr = map_addr;
                wr_data = map_data;
            end
        end
    end

    // Map RAM write; the read in the pipeline block sees the pre-write value.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            map_mem[wr_addr] <= wr_data;
        end
    end

    // Off-screen positions read cell 0 so the RAM address never leaves the map.
    always_comb begin
        in_range  = (DrawX < 10'(MAP_W * 16)) && (DrawY < 10'(MAP_H * 16));
        cell_calc = CELL_W'(DrawY[8:4]) * CELL_W'(MAP_W) + CELL_W'(DrawX[9:4]);
        cell_d    = in_range ? cell_calc : '0;
        ctl_d     = '{px: DrawX[3:0], py: DrawY[3:0], in_range: in_range,
                      blank_n: blank_n_in, hs: hs_in, vs: vs_in};
    end

    // Pipeline registers; every stage holds while pix_en is low.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cell_s1_q  <= '0;
            ctl_s1_q   <= CTL_IDLE;
            tile_s2_q  <= '0;
            ctl_s2_q   <= CTL_IDLE;
            vis_s3_q   <= 1'b0;
            blank_s3_q <= 1'b0;
            hs_s3_q    <= 1'b1;
            vs_s3_q    <= 1'b1;
        end else if (pix_en) begin
            cell_s1_q  <= cell_d;
            ctl_s1_q   <= ctl_d;
            tile_s2_q  <= map_mem[cell_s1_q];
            ctl_s2_q   <= ctl_s1_q;
            vis_s3_q   <= ctl_s2_q.blank_n & ctl_s2_q.in_range & (state_q == RUN);
            blank_s3_q <= ctl_s2_q.blank_n;
            hs_s3_q    <= ctl_s2_q.hs;
            vs_s3_q    <= ctl_s2_q.vs;
        end
    end

    assign rom_addr = {tile_s2_q, ctl_s2_q.py, ctl_s2_q.px};

    tile_rom u_rom (
        .Clk   (Clk),
        .rd_en (pix_en),
        .addr  (rom_addr),
        .q     (rom_q)
    );

    // Visibility bit is registered with the ROM word, so index moves only on strobes.
    assign index       = vis_s3_q ? rom_q : 4'h0;
    assign blank_n_out = blank_s3_q;
    assign hs_out      = hs_s3_q;
    assign vs_out      = vs_s3_q;

endmodule
